// File: rtl/cache_mem_ctrl_if.sv
// Pipeline-side and data_mem-side signals of the M-stage cache/memory controller.
// The slave modport is the controller; the master modport is the pipeline/memory environment.
interface cache_mem_ctrl_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 17,
   parameter int CNT_WIDTH     = 32
);
   logic                     mem_read_m;
   logic                     mem_write_m;
   logic [ADDRESS_WIDTH-1:0] addr_m;
   logic                     hit_m;
   logic                     mem_ack;
   logic [DATA_WIDTH-1:0]    mem_rd;
   logic                     mem_req;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic                     refill_we;
   logic                     cache_we;
   logic [DATA_WIDTH-1:0]    refill_data;
   logic                     use_refill;
   logic                     stall_mem;
   logic [CNT_WIDTH-1:0]     hit_count;
   logic [CNT_WIDTH-1:0]     miss_count;
   logic [CNT_WIDTH-1:0]     stall_count;

   modport slave (
      input  mem_read_m, mem_write_m, addr_m, hit_m, mem_ack, mem_rd,
      output mem_req, mem_we, mem_addr, refill_we, cache_we, refill_data,
             use_refill, stall_mem, hit_count, miss_count, stall_count
   );

   modport master (
      output mem_read_m, mem_write_m, addr_m, hit_m, mem_ack, mem_rd,
      input  mem_req, mem_we, mem_addr, refill_we, cache_we, refill_data,
             use_refill, stall_mem, hit_count, miss_count, stall_count
   );
endinterface

// File: rtl/cache_mem_ctrl.sv
// M-stage cache/data_mem sequencer: load-miss refill and write-through stores with pipeline stall.
// Optional saturating hit/miss/stall counters are built when CACHE_PERF_CNT_EN is defined.
module cache_mem_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 17,
   parameter int CNT_WIDTH     = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   cache_mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      REFILL  = 3'd2,
      WR_WAIT = 3'd3,
      WR_DONE = 3'd4
   } state_e;

   state_e                   state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    refill_data_q;
   logic                     hit_q;
   logic                     mem_req_q;
   logic                     mem_we_q;
   logic                     refill_we_q;
   logic                     cache_we_q;
   logic                     use_refill_q;

   logic idle_wr;
   logic idle_rd_miss;
   logic idle_rd_hit;
   logic stall;

   // A store takes priority over a load if both are flagged.
   assign idle_wr      = (state_q == IDLE) && bus.mem_write_m;
   assign idle_rd_miss = (state_q == IDLE) && !bus.mem_write_m && bus.mem_read_m && !bus.hit_m;
   assign idle_rd_hit  = (state_q == IDLE) && !bus.mem_write_m && bus.mem_read_m &&  bus.hit_m;

   assign stall = idle_wr || idle_rd_miss || (state_q == RD_WAIT) || (state_q == WR_WAIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         refill_data_q <= '0;
         hit_q         <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         refill_we_q   <= 1'b0;
         cache_we_q    <= 1'b0;
         use_refill_q  <= 1'b0;
      end else begin
         refill_we_q  <= 1'b0;
         cache_we_q   <= 1'b0;
         use_refill_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (idle_wr) begin
                  state_q   <= WR_WAIT;
                  addr_q    <= bus.addr_m;
                  hit_q     <= bus.hit_m;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b1;
               end else if (idle_rd_miss) begin
                  state_q   <= RD_WAIT;
                  addr_q    <= bus.addr_m;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (bus.mem_ack) begin
                  state_q       <= REFILL;
                  refill_data_q <= bus.mem_rd;
                  mem_req_q     <= 1'b0;
                  refill_we_q   <= 1'b1;
                  use_refill_q  <= 1'b1;
               end
            end
            REFILL: begin
               state_q <= IDLE;
            end
            WR_WAIT: begin
               if (bus.mem_ack) begin
                  state_q    <= WR_DONE;
                  mem_req_q  <= 1'b0;
                  mem_we_q   <= 1'b0;
                  cache_we_q <= hit_q;
               end
            end
            WR_DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.refill_we   = refill_we_q;
   assign bus.cache_we    = cache_we_q;
   assign bus.refill_data = refill_data_q;
   assign bus.use_refill  = use_refill_q;
   assign bus.stall_mem   = stall;

`ifdef CACHE_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] hit_cnt_q,   hit_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q,  miss_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (idle_rd_hit && (hit_cnt_q != '1))
         hit_cnt_d = hit_cnt_q + CNT_ONE;
      if (idle_rd_miss && (miss_cnt_q != '1))
         miss_cnt_d = miss_cnt_q + CNT_ONE;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.hit_count   = hit_cnt_q;
   assign bus.miss_count  = miss_cnt_q;
   assign bus.stall_count = stall_cnt_q;
`else
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

   logic unused_hit;
   assign unused_hit = idle_rd_hit;

   assign bus.hit_count   = CNT_ZERO;
   assign bus.miss_count  = CNT_ZERO;
   assign bus.stall_count = CNT_ZERO;
`endif
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Randomized scoreboard bench for cache_mem_ctrl: the driver plays pipeline and data_mem,
// a negedge monitor pops expected memory transactions and checks their completion cycle.
module tb_cache_mem_ctrl;
   localparam int DW = 32;
   localparam int AW = 17;
   localparam int CW = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk_i = ~clk_i;

   cache_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   cache_mem_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      bit              is_write;
      bit              hit;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } exp_t;

   exp_t exp_q[$];
   exp_t pend;
   bit   pend_vld = 0;

   int vectors     = 0;
   int miscompares = 0;
   int stall_seen  = 0;
   int exp_stall   = 0;
   int exp_hits    = 0;
   int exp_miss    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] cnt_exp(input int v);
`ifdef CACHE_PERF_CNT_EN
      return (v > (2**CW - 1)) ? 64'(2**CW - 1) : 64'(v);
`else
      return 64'(v) & 64'd0;
`endif
   endfunction

   // Monitor: scoreboard pop on each accepted handshake, completion check one cycle later.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (bus.stall_mem) stall_seen++;
         if (pend_vld) begin
            pend_vld = 0;
            check("done_stall", bus.stall_mem, 0);
            check("done_req",   bus.mem_req,   0);
            if (pend.is_write) begin
               check("wr_cache_we",  bus.cache_we,  pend.hit);
               check("wr_refill_we", bus.refill_we, 0);
            end else begin
               check("rd_refill_we",   bus.refill_we,   1);
               check("rd_use_refill",  bus.use_refill,  1);
               check("rd_refill_data", bus.refill_data, pend.data);
               check("rd_cache_we",    bus.cache_we,    0);
            end
         end else begin
            check("idle_strobes", {bus.refill_we, bus.cache_we, bus.use_refill}, 0);
         end
         if (bus.mem_req && bus.mem_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req", 1, 0);
            end else begin
               pend     = exp_q.pop_front();
               pend_vld = 1;
               check("req_we",    bus.mem_we,    pend.is_write);
               check("req_addr",  bus.mem_addr,  pend.addr);
               check("req_stall", bus.stall_mem, 1);
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         bus.mem_read_m  = 0;
         bus.mem_write_m = 0;
         bus.hit_m       = 1'($urandom);
         bus.addr_m      = AW'($urandom);
         bus.mem_ack     = 1'($urandom);
         bus.mem_rd      = $urandom;
      end
   endtask

   // One M-stage instruction; w = RD_WAIT/WR_WAIT cycles before the ack cycle.
   task automatic op(input bit rd, input bit wr, input logic [AW-1:0] a, input bit hit,
                     input int w, input logic [DW-1:0] data);
      exp_t e;
      @(posedge clk_i); #1;
      bus.mem_read_m  = rd;
      bus.mem_write_m = wr;
      bus.addr_m      = a;
      bus.hit_m       = hit;
      bus.mem_ack     = 0;
      bus.mem_rd      = $urandom;
      if (!rd && !wr) return;
      if (!wr && hit) begin
         exp_hits++;
         return;
      end
      e.is_write = wr;
      e.hit      = hit;
      e.addr     = a;
      e.data     = data;
      exp_q.push_back(e);
      if (!wr) exp_miss++;
      exp_stall += 2 + w;
      for (int i = 0; i < w; i++) begin
         @(posedge clk_i); #1;
         bus.addr_m = AW'($urandom);
         bus.hit_m  = 1'($urandom);
         bus.mem_rd = $urandom;
      end
      @(posedge clk_i); #1;
      bus.addr_m  = AW'($urandom);
      bus.hit_m   = 1'($urandom);
      bus.mem_ack = 1;
      bus.mem_rd  = data;
      @(posedge clk_i); #1;
      bus.mem_ack     = 1'($urandom);
      bus.mem_read_m  = 1'($urandom);
      bus.mem_write_m = 1'($urandom);
      bus.hit_m       = 1'($urandom);
      bus.mem_rd      = $urandom;
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_hit_count"},   bus.hit_count,   cnt_exp(exp_hits));
      check({tag, "_miss_count"},  bus.miss_count,  cnt_exp(exp_miss));
      check({tag, "_stall_count"}, bus.stall_count, cnt_exp(exp_stall));
   endtask

   initial begin
      bus.mem_read_m  = 0;
      bus.mem_write_m = 0;
      bus.addr_m      = '0;
      bus.hit_m       = 0;
      bus.mem_ack     = 0;
      bus.mem_rd      = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_req",        bus.mem_req,     0);
      check("rst_we",         bus.mem_we,      0);
      check("rst_stall",      bus.stall_mem,   0);
      check("rst_refill_we",  bus.refill_we,   0);
      check("rst_cache_we",   bus.cache_we,    0);
      check("rst_use_refill", bus.use_refill,  0);
      check("rst_refill_dat", bus.refill_data, 0);
      check("rst_mem_addr",   bus.mem_addr,    0);
      check_counters("rst");
      rst_i = 0;

      // Directed cases from the feature list.
      op(1, 0, 17'h00100, 1, 0, 32'h0);
      op(1, 0, 17'h00104, 0, 2, 32'hDEADBEEF);
      op(0, 1, 17'h00200, 1, 0, 32'h0);
      op(0, 1, 17'h00200, 0, 0, 32'h0);
      op(1, 1, 17'h00300, 1, 3, 32'h0);
      idle(3);
      check("dir_stall_cycles", stall_seen, exp_stall);
      check("dir_queue_empty",  exp_q.size(), 0);
      check("dir_refill_hold",  bus.refill_data, 32'hDEADBEEF);

      // Reset while a miss is outstanding, followed by a late ack.
      @(posedge clk_i); #1;
      bus.mem_read_m = 1; bus.mem_write_m = 0; bus.hit_m = 0; bus.addr_m = 17'h00444;
      bus.mem_ack = 0;
      @(posedge clk_i); #1;
      check("abort_req_before", bus.mem_req, 1);
      rst_i = 1;
      bus.mem_read_m = 0;
      @(posedge clk_i); #1;
      rst_i = 0;
      bus.mem_ack = 1;
      bus.mem_rd  = 32'h12345678;
      check("abort_req",    bus.mem_req,     0);
      check("abort_stall",  bus.stall_mem,   0);
      check("abort_refill", bus.refill_data, 0);
      idle(3);
      check("abort_no_refill", bus.refill_data, 0);
      stall_seen = 0;
      exp_stall = 0; exp_hits = 0; exp_miss = 0;
      check_counters("post_rst");

      // Two hits and one miss with a two-cycle ack.
      op(1, 0, 17'h00010, 1, 0, 32'h0);
      op(1, 0, 17'h00014, 1, 0, 32'h0);
      op(1, 0, 17'h00018, 0, 1, 32'hCAFEF00D);
      idle(2);
      check_counters("perf");

      // Random traffic; pushes counters past saturation.
      for (int n = 0; n < 80; n++) begin
         int k;
         k = $urandom_range(0, 4);
         case (k)
            0: op(1, 0, AW'($urandom), 1, 0, 32'h0);
            1: op(1, 0, AW'($urandom), 0, $urandom_range(0, 4), $urandom);
            2: op(0, 1, AW'($urandom), 1'($urandom), $urandom_range(0, 4), 32'h0);
            3: op(1, 1, AW'($urandom), 1'($urandom), $urandom_range(0, 3), 32'h0);
            default: idle($urandom_range(1, 2));
         endcase
      end
      idle(3);
      check("rand_stall_cycles", stall_seen, exp_stall);
      check("rand_queue_empty",  exp_q.size(), 0);
      check("rand_pending",      pend_vld, 0);
      check_counters("rand");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
